axi4opt_reg_slice: RTL and testbench
====================================

Name: axi4opt_reg_slice

Overview:
- Parametrised AXI4 register slice carrying the full optional-signal set: ID, USER, LOCK, CACHE, PROT, QOS and REGION.
- Inserted between an AXI4 master and slave to break timing paths. Each of the five channels (AW, W, B, AR, R) has its own selectable mode: bypass, forward-registered or full skid buffer.
- Reports per-channel occupancy and an idle flag for clock-gating and drain logic.

Parameters:
- ADDR_WIDTH, 16, address width on AW and AR.
- DATA_WIDTH, 64, data width on W and R. Strobe width is DATA_WIDTH/8. Must be a multiple of 8.
- ID_WIDTH, 4, width of AWID, ARID, BID and RID.
- USER_WIDTH, 8, width of all xUSER fields.
- AW_MODE, 2, AW channel mode: 0 = bypass, 1 = forward-registered, 2 = full skid.
- W_MODE, 2, W channel mode, same encoding.
- B_MODE, 1, B channel mode, same encoding.
- AR_MODE, 2, AR channel mode, same encoding.
- R_MODE, 2, R channel mode, same encoding.

Ports:
- i_clk  input  1  clock; every register is rising-edge.
- i_rst  input  1  synchronous reset, active-high.
- s_axi  interface  -  AXI4opt_iface.slave modport, facing the upstream master.
- m_axi  interface  -  AXI4opt_iface.master modport, facing the downstream slave.
- o_busy  output  5  per-channel "holds data" flag; bit order {R, AR, B, W, AW}, AW in bit 0.
- o_idle  output  1  high when o_busy == 0.

Behaviour:
- Forward channels: AW, W and AR run s_axi -> m_axi. Response channels: B and R run m_axi -> s_axi.
- Each channel's payload is the concatenation of every field of that channel except valid and ready:
  - AW/AR: addr, len, size, burst, id, user, lock, cache, prot, qos, region.
  - W: data, strb, last, user.
  - B: resp, id, user.
  - R: data, resp, last, id, user.
- A handshake occurs in a cycle where valid & ready are both high. Payload is transferred unmodified, in order, with no beat dropped or duplicated.
- Mode 0 (bypass):
  - Pure wires, zero latency.
  - o_busy bit is constant 0.
  - No registers are inferred for the channel.
- Mode 1 (forward-registered):
  - One payload register plus a valid flop. Latency 1 cycle.
  - Input ready = !out_valid | out_ready. This is combinational from the downstream ready.
  - On an input handshake, load the payload and set out_valid.
  - On an output handshake with no input handshake, clear out_valid.
  - Full throughput: one beat per cycle is sustained while downstream ready is held high.
  - o_busy = out_valid.
- Mode 2 (full skid):
  - Main register and skid register. Input ready is driven directly from a flop, so there is no combinational ready path. Latency 1 cycle.
  - States: EMPTY, ONE (main valid), FULL (main and skid valid).
  - EMPTY: on in_hs, go to ONE and load main.
  - ONE, in_hs & !out_hs: go to FULL and load skid.
  - ONE, !in_hs & out_hs: go to EMPTY.
  - ONE, both: stay in ONE and load main with the new beat.
  - FULL: out_hs -> ONE; main <= skid.
  - in_hs cannot occur in FULL because in_ready = 0.
  - out_valid = state != EMPTY. The output payload is always taken from main.
  - in_ready flop = 1 in EMPTY and ONE, 0 in FULL. The flop is updated with the next state.
  - o_busy = state != EMPTY.
- Reset:
  - While i_rst is high, all valid flops are 0 and all states are EMPTY.
  - Mode-2 in_ready is 0 during reset. It goes high on the first rising edge after i_rst deasserts.
  - Payload registers are not reset and are don't-care while invalid.
  - Reset mid-operation discards held beats silently. Outputs reach their reset values one edge after i_rst is sampled high.
- Valid/payload stability:
  - Once out_valid is asserted, out_valid and payload stay constant until out_hs, as AXI requires.
  - A mode-2 skid load never alters main while out_valid & !out_ready.
- Channels are fully independent. There is no AW/W or AR/R ordering coupling inside the slice.
- Illegal mode values (>2) are caught by an elaboration-time check that stops elaboration with an error.

Test Plan:
- Reset:
  - Stimulus: i_rst high for 3 cycles, all modes at default.
  - Required: all m_axi valid = 0, s_axi ready on AW/W/AR = 0 during reset and 1 one cycle after release, o_idle = 1.
- Back-to-back, mode 2 AW:
  - Stimulus: m_axi.if_awready held 1; 8 AW beats with awaddr 0x0000..0x0070 step 0x10, awid 0..7, on consecutive cycles.
  - Required: identical beats appear on m_axi one cycle later, 1 beat/cycle, s_axi.if_awready never drops.
- Backpressure, mode 2 W:
  - Stimulus: m_axi.if_wready = 0; drive wdata 0xA1, 0xA2, 0xA3.
  - Required: 0xA1 and 0xA2 accepted, wready falls after the second handshake, 0xA3 held at input.
  - Then: wready = 1 → output order is 0xA1, 0xA2, 0xA3, o_busy[1] clears after the last beat.
- Mode 1 B:
  - Stimulus: bresp = 2'b10, bid = 3, bready toggling 0/1 every cycle.
  - Required: each beat delivered once, latency 1, upstream bready mirrors (!bvalid | downstream bready) combinationally.
- Bypass:
  - Stimulus: R_MODE = 0; rdata 0xDEADBEEF_CAFEF00D with rlast = 1.
  - Required: appears on s_axi in the same cycle, o_busy[4] = 0 throughout.
- Reset mid-flight:
  - Stimulus: AR in FULL state holding 2 beats; assert i_rst for 1 cycle.
  - Required: m_axi.if_arvalid = 0 next cycle, the held beats are never emitted, o_idle = 1.

Source files
------------

// File: rtl/axi4opt_reg_slice_if.sv
// AXI4 bus with the full optional-signal set (ID, USER, LOCK, CACHE, PROT, QOS, REGION).
// The master modport drives AW/W/AR and the B/R ready signals; the slave modport is its mirror.
interface AXI4opt_iface #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0]   if_awaddr;
    logic [7:0]              if_awlen;
    logic [2:0]              if_awsize;
    logic [1:0]              if_awburst;
    logic [ID_WIDTH-1:0]     if_awid;
    logic [USER_WIDTH-1:0]   if_awuser;
    logic                    if_awlock;
    logic [3:0]              if_awcache;
    logic [2:0]              if_awprot;
    logic [3:0]              if_awqos;
    logic [3:0]              if_awregion;
    logic                    if_awvalid;
    logic                    if_awready;

    logic [DATA_WIDTH-1:0]   if_wdata;
    logic [DATA_WIDTH/8-1:0] if_wstrb;
    logic                    if_wlast;
    logic [USER_WIDTH-1:0]   if_wuser;
    logic                    if_wvalid;
    logic                    if_wready;

    logic [1:0]              if_bresp;
    logic [ID_WIDTH-1:0]     if_bid;
    logic [USER_WIDTH-1:0]   if_buser;
    logic                    if_bvalid;
    logic                    if_bready;

    logic [ADDR_WIDTH-1:0]   if_araddr;
    logic [7:0]              if_arlen;
    logic [2:0]              if_arsize;
    logic [1:0]              if_arburst;
    logic [ID_WIDTH-1:0]     if_arid;
    logic [USER_WIDTH-1:0]   if_aruser;
    logic                    if_arlock;
    logic [3:0]              if_arcache;
    logic [2:0]              if_arprot;
    logic [3:0]              if_arqos;
    logic [3:0]              if_arregion;
    logic                    if_arvalid;
    logic                    if_arready;

    logic [DATA_WIDTH-1:0]   if_rdata;
    logic [1:0]              if_rresp;
    logic                    if_rlast;
    logic [ID_WIDTH-1:0]     if_rid;
    logic [USER_WIDTH-1:0]   if_ruser;
    logic                    if_rvalid;
    logic                    if_rready;

    modport master (
        output if_awaddr, if_awlen, if_awsize, if_awburst, if_awid, if_awuser,
               if_awlock, if_awcache, if_awprot, if_awqos, if_awregion, if_awvalid,
        input  if_awready,
        output if_wdata, if_wstrb, if_wlast, if_wuser, if_wvalid,
        input  if_wready,
        input  if_bresp, if_bid, if_buser, if_bvalid,
        output if_bready,
        output if_araddr, if_arlen, if_arsize, if_arburst, if_arid, if_aruser,
               if_arlock, if_arcache, if_arprot, if_arqos, if_arregion, if_arvalid,
        input  if_arready,
        input  if_rdata, if_rresp, if_rlast, if_rid, if_ruser, if_rvalid,
        output if_rready
    );

    modport slave (
        input  if_awaddr, if_awlen, if_awsize, if_awburst, if_awid, if_awuser,
               if_awlock, if_awcache, if_awprot, if_awqos, if_awregion, if_awvalid,
        output if_awready,
        input  if_wdata, if_wstrb, if_wlast, if_wuser, if_wvalid,
        output if_wready,
        output if_bresp, if_bid, if_buser, if_bvalid,
        input  if_bready,
        input  if_araddr, if_arlen, if_arsize, if_arburst, if_arid, if_aruser,
               if_arlock, if_arcache, if_arprot, if_arqos, if_arregion, if_arvalid,
        output if_arready,
        output if_rdata, if_rresp, if_rlast, if_rid, if_ruser, if_rvalid,
        input  if_rready
    );
endinterface

// File: rtl/axi4opt_reg_slice.sv
// AXI4 register slice: each of AW, W, B, AR, R is independently bypassed, forward-registered
// or skid-buffered. o_busy flags channels holding a beat, o_idle is their NOR.
module axi4opt_reg_slice #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4,
    parameter int USER_WIDTH = 8,
    parameter int AW_MODE    = 2,
    parameter int W_MODE     = 2,
    parameter int B_MODE     = 1,
    parameter int AR_MODE    = 2,
    parameter int R_MODE     = 2
) (
    input  logic         i_clk,
    input  logic         i_rst,
    AXI4opt_iface.slave  s_axi,
    AXI4opt_iface.master m_axi,
    output logic [4:0]   o_busy,
    output logic         o_idle
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int AX_W   = ADDR_WIDTH + ID_WIDTH + USER_WIDTH + 29;
    localparam int W_W    = DATA_WIDTH + STRB_W + 1 + USER_WIDTH;
    localparam int B_W    = 2 + ID_WIDTH + USER_WIDTH;
    localparam int R_W    = DATA_WIDTH + 3 + ID_WIDTH + USER_WIDTH;
    localparam int CH_W    [5] = '{AX_W, W_W, B_W, AX_W, R_W};
    localparam int CH_MODE [5] = '{AW_MODE, W_MODE, B_MODE, AR_MODE, R_MODE};

    logic [4:0] busy;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_width
        $error("axi4opt_reg_slice: DATA_WIDTH must be a multiple of 8");
    end

    for (genvar c = 0; c < 5; c++) begin : g_ch
        localparam int W    = CH_W[c];
        localparam int MODE = CH_MODE[c];
        logic         in_valid, in_ready, out_valid, out_ready;
        logic [W-1:0] in_pl, out_pl;

        // Channel index -> bus wiring; B and R flow from m_axi back to s_axi.
        if (c == 0) begin : g_aw
            assign in_valid         = s_axi.if_awvalid;
            assign s_axi.if_awready = in_ready;
            assign in_pl = {s_axi.if_awaddr, s_axi.if_awlen, s_axi.if_awsize, s_axi.if_awburst,
                            s_axi.if_awid, s_axi.if_awuser, s_axi.if_awlock, s_axi.if_awcache,
                            s_axi.if_awprot, s_axi.if_awqos, s_axi.if_awregion};
            assign m_axi.if_awvalid = out_valid;
            assign out_ready        = m_axi.if_awready;
            assign {m_axi.if_awaddr, m_axi.if_awlen, m_axi.if_awsize, m_axi.if_awburst,
                    m_axi.if_awid, m_axi.if_awuser, m_axi.if_awlock, m_axi.if_awcache,
                    m_axi.if_awprot, m_axi.if_awqos, m_axi.if_awregion} = out_pl;
        end else if (c == 1) begin : g_w
            assign in_valid        = s_axi.if_wvalid;
            assign s_axi.if_wready = in_ready;
            assign in_pl = {s_axi.if_wdata, s_axi.if_wstrb, s_axi.if_wlast, s_axi.if_wuser};
            assign m_axi.if_wvalid = out_valid;
            assign out_ready       = m_axi.if_wready;
            assign {m_axi.if_wdata, m_axi.if_wstrb, m_axi.if_wlast, m_axi.if_wuser} = out_pl;
        end else if (c == 2) begin : g_b
            assign in_valid        = m_axi.if_bvalid;
            assign m_axi.if_bready = in_ready;
            assign in_pl = {m_axi.if_bresp, m_axi.if_bid, m_axi.if_buser};
            assign s_axi.if_bvalid = out_valid;
            assign out_ready       = s_axi.if_bready;
            assign {s_axi.if_bresp, s_axi.if_bid, s_axi.if_buser} = out_pl;
        end else if (c == 3) begin : g_ar
            assign in_valid         = s_axi.if_arvalid;
            assign s_axi.if_arready = in_ready;
            assign in_pl = {s_axi.if_araddr, s_axi.if_arlen, s_axi.if_arsize, s_axi.if_arburst,
                            s_axi.if_arid, s_axi.if_aruser, s_axi.if_arlock, s_axi.if_arcache,
                            s_axi.if_arprot, s_axi.if_arqos, s_axi.if_arregion};
            assign m_axi.if_arvalid = out_valid;
            assign out_ready        = m_axi.if_arready;
            assign {m_axi.if_araddr, m_axi.if_arlen, m_axi.if_arsize, m_axi.if_arburst,
                    m_axi.if_arid, m_axi.if_aruser, m_axi.if_arlock, m_axi.if_arcache,
                    m_axi.if_arprot, m_axi.if_arqos, m_axi.if_arregion} = out_pl;
        end else begin : g_r
            assign in_valid        = m_axi.if_rvalid;
            assign m_axi.if_rready = in_ready;
            assign in_pl = {m_axi.if_rdata, m_axi.if_rresp, m_axi.if_rlast, m_axi.if_rid,
                            m_axi.if_ruser};
            assign s_axi.if_rvalid = out_valid;
            assign out_ready       = s_axi.if_rready;
            assign {s_axi.if_rdata, s_axi.if_rresp, s_axi.if_rlast, s_axi.if_rid,
                    s_axi.if_ruser} = out_pl;
        end

        if (MODE == 0) begin : g_bypass
            assign in_ready  = out_ready;
            assign out_valid = in_valid;
            assign out_pl    = in_pl;
            assign busy[c]   = 1'b0;
        end else if (MODE == 1) begin : g_fwd
            logic         valid_q;
            logic [W-1:0] data_q;

            assign in_ready = !valid_q || out_ready;

            always_ff @(posedge i_clk) begin
                if (i_rst)                      valid_q <= 1'b0;
                else if (in_valid && in_ready)  valid_q <= 1'b1;
                else if (out_ready)             valid_q <= 1'b0;
            end

            always_ff @(posedge i_clk) begin
                if (in_valid && in_ready) data_q <= in_pl;
            end

            assign out_valid = valid_q;
            assign out_pl    = data_q;
            assign busy[c]   = valid_q;
        end else if (MODE == 2) begin : g_skid
            typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_e;
            state_e       state_q, state_d;
            logic         ready_q, in_hs, out_hs;
            logic         load_main_d, load_skid_d, skid_to_main_d;
            logic [W-1:0] main_q, skid_q;

            assign in_hs  = in_valid && ready_q;
            assign out_hs = (state_q != EMPTY) && out_ready;

            always_comb begin
                state_d        = state_q;
                load_main_d    = 1'b0;
                load_skid_d    = 1'b0;
                skid_to_main_d = 1'b0;
                case (state_q)
                    EMPTY: if (in_hs) begin
                        state_d     = ONE;
                        load_main_d = 1'b1;
                    end
                    ONE: begin
                        if (in_hs && !out_hs) begin
                            state_d     = FULL;
                            load_skid_d = 1'b1;
                        end else if (!in_hs && out_hs) begin
                            state_d = EMPTY;
                        end else if (in_hs && out_hs) begin
                            load_main_d = 1'b1;
                        end
                    end
                    FULL: if (out_hs) begin
                        state_d        = ONE;
                        skid_to_main_d = 1'b1;
                    end
                    default: state_d = EMPTY;
                endcase
            end

            // Ready is registered from the next state so no combinational path crosses the slice.
            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    state_q <= EMPTY;
                    ready_q <= 1'b0;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != FULL);
                end
            end

            always_ff @(posedge i_clk) begin
                if (load_main_d)         main_q <= in_pl;
                else if (skid_to_main_d) main_q <= skid_q;
                if (load_skid_d)         skid_q <= in_pl;
            end

            assign in_ready  = ready_q;
            assign out_valid = (state_q != EMPTY);
            assign out_pl    = main_q;
            assign busy[c]   = (state_q != EMPTY);
        end else begin : g_bad_mode
            $error("axi4opt_reg_slice: channel mode must be 0, 1 or 2");
        end
    end

    assign o_busy = busy;
    assign o_idle = (busy == 5'd0);
endmodule

// File: tb/tb_axi4opt_reg_slice.sv
// Directed bench for axi4opt_reg_slice with R in bypass; inputs change and outputs are sampled
// on the falling edge so every registered value is stable when looked at.
module tb_axi4opt_reg_slice;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] busy;
    logic       idle;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    AXI4opt_iface #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(8)) s_if ();
    AXI4opt_iface #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(8)) m_if ();

    axi4opt_reg_slice #(.R_MODE(0)) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .s_axi  (s_if.slave),
        .m_axi  (m_if.master),
        .o_busy (busy),
        .o_idle (idle)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_init();
        s_if.if_awaddr = '0; s_if.if_awlen = '0; s_if.if_awsize = 3'd3; s_if.if_awburst = 2'd1;
        s_if.if_awid = '0; s_if.if_awuser = 8'h5A; s_if.if_awlock = 1'b0; s_if.if_awcache = 4'h3;
        s_if.if_awprot = 3'd2; s_if.if_awqos = 4'h1; s_if.if_awregion = 4'h0; s_if.if_awvalid = 1'b0;
        s_if.if_wdata = '0; s_if.if_wstrb = 8'hFF; s_if.if_wlast = 1'b1; s_if.if_wuser = 8'h11;
        s_if.if_wvalid = 1'b0;
        s_if.if_araddr = '0; s_if.if_arlen = '0; s_if.if_arsize = 3'd3; s_if.if_arburst = 2'd1;
        s_if.if_arid = '0; s_if.if_aruser = 8'h00; s_if.if_arlock = 1'b0; s_if.if_arcache = 4'h0;
        s_if.if_arprot = 3'd0; s_if.if_arqos = 4'h0; s_if.if_arregion = 4'h0; s_if.if_arvalid = 1'b0;
        s_if.if_bready = 1'b0; s_if.if_rready = 1'b0;
        m_if.if_awready = 1'b0; m_if.if_wready = 1'b0; m_if.if_arready = 1'b0;
        m_if.if_bresp = 2'b00; m_if.if_bid = '0; m_if.if_buser = '0; m_if.if_bvalid = 1'b0;
        m_if.if_rdata = '0; m_if.if_rresp = 2'b00; m_if.if_rlast = 1'b0; m_if.if_rid = '0;
        m_if.if_ruser = '0; m_if.if_rvalid = 1'b0;
    endtask

    initial begin
        bus_init();

        // Reset held for three rising edges.
        repeat (3) @(negedge clk);
        #1;
        chk("rst_awvalid", m_if.if_awvalid, 1'b0);
        chk("rst_wvalid",  m_if.if_wvalid,  1'b0);
        chk("rst_arvalid", m_if.if_arvalid, 1'b0);
        chk("rst_bvalid",  s_if.if_bvalid,  1'b0);
        chk("rst_awready", s_if.if_awready, 1'b0);
        chk("rst_wready",  s_if.if_wready,  1'b0);
        chk("rst_arready", s_if.if_arready, 1'b0);
        chk("rst_idle",    idle,            1'b1);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("rel_awready", s_if.if_awready, 1'b1);
        chk("rel_wready",  s_if.if_wready,  1'b1);
        chk("rel_arready", s_if.if_arready, 1'b1);
        chk("rel_idle",    idle,            1'b1);

        // AW skid: eight beats back to back, output trails by one cycle.
        m_if.if_awready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            s_if.if_awvalid = 1'b1;
            s_if.if_awaddr  = 16'(k * 16);
            s_if.if_awid    = 4'(k);
            s_if.if_awlen   = 8'(k + 1);
            #1;
            chk("aw_ready", s_if.if_awready, 1'b1);
            if (k > 0) begin
                chk("aw_out_valid", m_if.if_awvalid, 1'b1);
                chk("aw_out_addr",  m_if.if_awaddr,  (k - 1) * 16);
                chk("aw_out_id",    m_if.if_awid,    k - 1);
                chk("aw_out_len",   m_if.if_awlen,   k);
            end
        end
        @(negedge clk);
        s_if.if_awvalid = 1'b0;
        #1;
        chk("aw_last_addr",  m_if.if_awaddr,  16'h0070);
        chk("aw_last_id",    m_if.if_awid,    4'd7);
        chk("aw_last_user",  m_if.if_awuser,  8'h5A);
        chk("aw_last_cache", m_if.if_awcache, 4'h3);
        @(negedge clk); #1;
        chk("aw_drained", m_if.if_awvalid, 1'b0);
        chk("aw_busy0",   busy[0],         1'b0);

        // W skid under backpressure.
        m_if.if_wready = 1'b0;
        @(negedge clk);
        s_if.if_wvalid = 1'b1; s_if.if_wdata = 64'hA1;
        #1;
        chk("w_ready_a1", s_if.if_wready, 1'b1);
        @(negedge clk);
        s_if.if_wdata = 64'hA2;
        #1;
        chk("w_ready_a2", s_if.if_wready, 1'b1);
        chk("w_valid_a1", m_if.if_wvalid, 1'b1);
        chk("w_data_a1",  m_if.if_wdata,  64'hA1);
        @(negedge clk);
        s_if.if_wdata = 64'hA3;
        #1;
        chk("w_ready_full", s_if.if_wready, 1'b0);
        chk("w_data_hold1", m_if.if_wdata,  64'hA1);
        chk("w_busy1",      busy[1],        1'b1);
        @(negedge clk); #1;
        chk("w_ready_hold", s_if.if_wready, 1'b0);
        chk("w_data_hold2", m_if.if_wdata,  64'hA1);
        chk("w_strb",       m_if.if_wstrb,  8'hFF);
        m_if.if_wready = 1'b1;
        @(negedge clk); #1;
        chk("w_data_a2",     m_if.if_wdata,  64'hA2);
        chk("w_ready_after", s_if.if_wready, 1'b1);
        @(negedge clk);
        s_if.if_wvalid = 1'b0;
        #1;
        chk("w_data_a3",  m_if.if_wdata,  64'hA3);
        chk("w_valid_a3", m_if.if_wvalid, 1'b1);
        @(negedge clk); #1;
        chk("w_drained", m_if.if_wvalid, 1'b0);
        chk("w_busy0",   busy[1],        1'b0);

        // B forward-registered, upstream ready toggling; buser tags each beat.
        m_if.if_bresp = 2'b10; m_if.if_bid = 4'd3;
        @(negedge clk);
        s_if.if_bready = 1'b0; m_if.if_bvalid = 1'b1; m_if.if_buser = 8'd1;
        #1;
        chk("b_rdy_empty", m_if.if_bready, 1'b1);
        chk("b_no_out",    s_if.if_bvalid, 1'b0);
        @(negedge clk);
        s_if.if_bready = 1'b1; m_if.if_buser = 8'd2;
        #1;
        chk("b_valid1", s_if.if_bvalid, 1'b1);
        chk("b_user1",  s_if.if_buser,  8'd1);
        chk("b_resp1",  s_if.if_bresp,  2'b10);
        chk("b_id1",    s_if.if_bid,    4'd3);
        chk("b_rdy_1",  m_if.if_bready, 1'b1);
        @(negedge clk);
        s_if.if_bready = 1'b0; m_if.if_buser = 8'd3;
        #1;
        chk("b_user2", s_if.if_buser,  8'd2);
        chk("b_rdy_0", m_if.if_bready, 1'b0);
        @(negedge clk);
        s_if.if_bready = 1'b1;
        #1;
        chk("b_user2_hold", s_if.if_buser,  8'd2);
        chk("b_rdy_2",      m_if.if_bready, 1'b1);
        @(negedge clk);
        s_if.if_bready = 1'b0; m_if.if_bvalid = 1'b0;
        #1;
        chk("b_user3",   s_if.if_buser,  8'd3);
        chk("b_rdy_3",   m_if.if_bready, 1'b0);
        @(negedge clk);
        s_if.if_bready = 1'b1;
        #1;
        chk("b_user3_hold", s_if.if_buser,  8'd3);
        chk("b_valid3",     s_if.if_bvalid, 1'b1);
        @(negedge clk);
        s_if.if_bready = 1'b0;
        #1;
        chk("b_drained",  s_if.if_bvalid, 1'b0);
        chk("b_busy0",    busy[2],        1'b0);
        chk("b_rdy_idle", m_if.if_bready, 1'b1);

        // R bypass: same-cycle pass-through, never busy.
        @(negedge clk);
        m_if.if_rvalid = 1'b1; m_if.if_rdata = 64'hDEADBEEF_CAFEF00D; m_if.if_rlast = 1'b1;
        m_if.if_rid = 4'd5; s_if.if_rready = 1'b0;
        #1;
        chk("r_valid", s_if.if_rvalid, 1'b1);
        chk("r_data",  s_if.if_rdata,  64'hDEADBEEF_CAFEF00D);
        chk("r_last",  s_if.if_rlast,  1'b1);
        chk("r_id",    s_if.if_rid,    4'd5);
        chk("r_rdy0",  m_if.if_rready, 1'b0);
        chk("r_busy",  busy[4],        1'b0);
        s_if.if_rready = 1'b1;
        #1;
        chk("r_rdy1", m_if.if_rready, 1'b1);
        @(negedge clk);
        m_if.if_rvalid = 1'b0;
        #1;
        chk("r_gone",   s_if.if_rvalid, 1'b0);
        chk("r_busy_b", busy[4],        1'b0);

        // AR filled to FULL, then reset discards both beats.
        @(negedge clk);
        s_if.if_arvalid = 1'b1; s_if.if_araddr = 16'h0100; s_if.if_arid = 4'd1;
        @(negedge clk);
        s_if.if_araddr = 16'h0200; s_if.if_arid = 4'd2;
        #1;
        chk("ar_ready_one", s_if.if_arready, 1'b1);
        @(negedge clk);
        s_if.if_arvalid = 1'b0;
        #1;
        chk("ar_valid_full", m_if.if_arvalid, 1'b1);
        chk("ar_addr_full",  m_if.if_araddr,  16'h0100);
        chk("ar_ready_full", s_if.if_arready, 1'b0);
        chk("ar_busy",       busy[3],         1'b1);
        chk("ar_not_idle",   idle,            1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ar_rst_valid", m_if.if_arvalid, 1'b0);
        chk("ar_rst_ready", s_if.if_arready, 1'b0);
        chk("ar_rst_idle",  idle,            1'b1);
        m_if.if_arready = 1'b1;
        @(negedge clk); #1;
        chk("ar_post_valid", m_if.if_arvalid, 1'b0);
        chk("ar_post_ready", s_if.if_arready, 1'b1);
        @(negedge clk); #1;
        chk("ar_post_valid2", m_if.if_arvalid, 1'b0);
        chk("ar_post_idle",   idle,            1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
